// File: rtl/exec_result_buffer_pkg.sv
// Shared types for the execution-result buffer and its handshake interface.
package exec_result_buffer_pkg;

    // xer[0] is the MSB (SO); bit-0-is-MSB numbering matches the rest of the datapath.
    typedef struct packed {
        logic [0:31] xer;
        logic        xer_valid;
        logic        cr0_valid;
    } cond_exception_t;

endpackage

// File: rtl/exec_result_buffer_if.sv
// Result handshake from the execution unit plus the CDB drain handshake.
interface exec_result_buffer_if #(
    parameter int RS_ID_WIDTH = 5
);
    import exec_result_buffer_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [RS_ID_WIDTH-1:0] in_rs_id;
    logic [4:0]             in_reg_addr;
    logic [31:0]            in_result;
    cond_exception_t        in_cr0_xer;

    logic                   cdb_valid;
    logic                   cdb_ready;
    logic [RS_ID_WIDTH-1:0] cdb_rs_id;
    logic [4:0]             cdb_reg_addr;
    logic [31:0]            cdb_result;
    logic                   cdb_cr0_we;
    logic [3:0]             cdb_cr0;
    logic                   cdb_xer_we;
    logic [31:0]            cdb_xer;

    // Buffer side
    modport slave (
        input  in_valid, in_rs_id, in_reg_addr, in_result, in_cr0_xer, cdb_ready,
        output in_ready, cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_result,
               cdb_cr0_we, cdb_cr0, cdb_xer_we, cdb_xer
    );

    // Execution unit / CDB side
    modport master (
        output in_valid, in_rs_id, in_reg_addr, in_result, in_cr0_xer, cdb_ready,
        input  in_ready, cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_result,
               cdb_cr0_we, cdb_cr0, cdb_xer_we, cdb_xer
    );

endinterface

// File: rtl/exec_result_buffer.sv
// In-order FIFO between an execution unit and the CDB; CR0 is computed on entry
// so the drain side is a pure register read.
module exec_result_buffer #(
    parameter int RS_ID_WIDTH = 5,
    parameter int DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    exec_result_buffer_if.slave      bus,
    output logic [$clog2(DEPTH):0]   o_occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_rst_done;

    logic [RS_ID_WIDTH-1:0] r_rs_id   [DEPTH];
    logic [4:0]             r_reg     [DEPTH];
    logic [31:0]            r_result  [DEPTH];
    logic                   r_cr0_we  [DEPTH];
    logic [3:0]             r_cr0     [DEPTH];
    logic                   r_xer_we  [DEPTH];
    logic [31:0]            r_xer     [DEPTH];

    logic                   w_push;
    logic                   w_pop;
    logic                   w_not_empty;
    logic                   w_lt;
    logic                   w_gt;
    logic                   w_eq;
    logic                   w_so;

    // r_rst_done keeps in_ready low for the first edge after reset release.
    assign bus.in_ready = rst_n & r_rst_done & (r_count < CNT_W'(DEPTH));
    assign w_not_empty  = (r_count != '0);
    assign w_push       = bus.in_valid & bus.in_ready;
    assign w_pop        = w_not_empty & bus.cdb_ready;

    // in_result[31] is the architectural bit 0 (sign).
    assign w_lt = bus.in_result[31];
    assign w_eq = (bus.in_result == 32'h0);
    assign w_gt = ~w_lt & ~w_eq;
    assign w_so = bus.in_cr0_xer.xer[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: it is only visible while its entry is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rs_id[r_wr_ptr]  <= bus.in_rs_id;
            r_reg[r_wr_ptr]    <= bus.in_reg_addr;
            r_result[r_wr_ptr] <= bus.in_result;
            r_cr0_we[r_wr_ptr] <= bus.in_cr0_xer.cr0_valid;
            r_cr0[r_wr_ptr]    <= {w_lt, w_gt, w_eq, w_so};
            r_xer_we[r_wr_ptr] <= bus.in_cr0_xer.xer_valid;
            r_xer[r_wr_ptr]    <= bus.in_cr0_xer.xer;
        end
    end

    assign bus.cdb_valid    = w_not_empty;
    assign bus.cdb_rs_id    = w_not_empty ? r_rs_id[r_rd_ptr]  : '0;
    assign bus.cdb_reg_addr = w_not_empty ? r_reg[r_rd_ptr]    : '0;
    assign bus.cdb_result   = w_not_empty ? r_result[r_rd_ptr] : '0;
    assign bus.cdb_cr0_we   = w_not_empty & r_cr0_we[r_rd_ptr];
    assign bus.cdb_cr0      = w_not_empty ? r_cr0[r_rd_ptr]    : '0;
    assign bus.cdb_xer_we   = w_not_empty & r_xer_we[r_rd_ptr];
    assign bus.cdb_xer      = w_not_empty ? r_xer[r_rd_ptr]    : '0;
    assign o_occupancy      = r_count;

endmodule
